// File: rtl/dec_alu_pipe_stage.sv
// rtl/dec_alu_pipe_stage.sv - DEC->ALU pipeline register with valid/ready, stall, flush and optional skid entry
module dec_alu_pipe_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4,
    parameter int DC_CTRL_W  = 3,
    parameter int SKID_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_W-1:0]     dataReg1,
    input  logic [DATA_W-1:0]     dataReg2,
    input  logic [DATA_W-1:0]     immValueIn,
    input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
    input  logic [ALU_OP_W-1:0]   ALUop,
    input  logic                  writeEnableReg,
    input  logic [DC_CTRL_W-1:0]  dataCacheControlIn,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_W-1:0]     dataAlu1,
    output logic [DATA_W-1:0]     dataAlu2,
    output logic [DATA_W-1:0]     immValueOut,
    output logic [REG_ADDR_W-1:0] writeBackAddrOut,
    output logic [ALU_OP_W-1:0]   op,
    output logic                  writeEnableAlu,
    output logic [DC_CTRL_W-1:0]  dataCacheControlOut,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]     d1;
        logic [DATA_W-1:0]     d2;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] wb;
        logic [ALU_OP_W-1:0]   op;
        logic                  we;
        logic [DC_CTRL_W-1:0]  dc;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_payload;
    logic     in_ready_q, in_ready_d;
    logic     in_fire, out_fire, out_valid;

    assign in_payload = '{d1: dataReg1, d2: dataReg2, imm: immValueIn, wb: writeBackAddrIn,
                          op: ALUop, we: writeEnableReg, dc: dataCacheControlIn};

    assign out_valid = (state_q != EMPTY);
    assign inReady   = (SKID_EN != 0) ? in_ready_q : (!out_valid || outReady);
    assign in_fire   = inValid && inReady;
    assign out_fire  = out_valid && outReady;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
            // Payload is left stale; bubble gating below hides it.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_payload;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_payload;
                    end else if (in_fire && (SKID_EN != 0)) begin
                        skid_d  = in_payload;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign outValid            = out_valid;
    assign dataAlu1            = main_q.d1;
    assign dataAlu2            = main_q.d2;
    assign immValueOut         = main_q.imm;
    assign writeBackAddrOut    = main_q.wb;
    assign op                  = main_q.op;
    assign writeEnableAlu      = main_q.we && out_valid;
    assign dataCacheControlOut = main_q.dc & {DC_CTRL_W{out_valid}};
    assign occupancy           = state_q;

endmodule

// File: tb/tb_dec_alu_pipe_stage.sv
// tb/tb_dec_alu_pipe_stage.sv - table-driven and scoreboard bench for dec_alu_pipe_stage
module tb_dec_alu_pipe_stage;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  wb;
        logic [3:0]  op;
        logic        we;
        logic [2:0]  dc;
    } pl_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] d1;
        logic [1:0]  occ;
        logic        rdy;
    } vec_t;

    logic        clk, rstN, flush, inValid, outReady;
    logic [31:0] dataReg1, dataReg2, immValueIn;
    logic [4:0]  writeBackAddrIn;
    logic [3:0]  ALUop;
    logic        writeEnableReg;
    logic [2:0]  dataCacheControlIn;

    logic        inReady, outValid, writeEnableAlu;
    logic [31:0] dataAlu1, dataAlu2, immValueOut;
    logic [4:0]  writeBackAddrOut;
    logic [3:0]  op;
    logic [2:0]  dataCacheControlOut;
    logic [1:0]  occupancy;

    logic        inReady0, outValid0, writeEnableAlu0;
    logic [31:0] dataAlu1_0, dataAlu2_0, immValueOut0;
    logic [4:0]  writeBackAddrOut0;
    logic [3:0]  op0;
    logic [2:0]  dataCacheControlOut0;
    logic [1:0]  occupancy0;

    int   n_cmp = 0;
    int   n_fail = 0;
    pl_t  sb[$];
    pl_t  cur;
    vec_t tbl[10];

    dec_alu_pipe_stage #(.SKID_EN(1)) u_dut (
        .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(inReady),
        .dataReg1(dataReg1), .dataReg2(dataReg2), .immValueIn(immValueIn),
        .writeBackAddrIn(writeBackAddrIn), .ALUop(ALUop), .writeEnableReg(writeEnableReg),
        .dataCacheControlIn(dataCacheControlIn), .outValid(outValid), .outReady(outReady),
        .dataAlu1(dataAlu1), .dataAlu2(dataAlu2), .immValueOut(immValueOut),
        .writeBackAddrOut(writeBackAddrOut), .op(op), .writeEnableAlu(writeEnableAlu),
        .dataCacheControlOut(dataCacheControlOut), .occupancy(occupancy)
    );

    dec_alu_pipe_stage #(.SKID_EN(0)) u_dut0 (
        .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(inReady0),
        .dataReg1(dataReg1), .dataReg2(dataReg2), .immValueIn(immValueIn),
        .writeBackAddrIn(writeBackAddrIn), .ALUop(ALUop), .writeEnableReg(writeEnableReg),
        .dataCacheControlIn(dataCacheControlIn), .outValid(outValid0), .outReady(outReady),
        .dataAlu1(dataAlu1_0), .dataAlu2(dataAlu2_0), .immValueOut(immValueOut0),
        .writeBackAddrOut(writeBackAddrOut0), .op(op0), .writeEnableAlu(writeEnableAlu0),
        .dataCacheControlOut(dataCacheControlOut0), .occupancy(occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pl_t mk(input logic [31:0] v);
        pl_t p;
        p.d1  = v;
        p.d2  = ~v;
        p.imm = v << 4;
        p.wb  = v[4:0];
        p.op  = v[3:0] ^ 4'h9;
        p.we  = v[0];
        p.dc  = v[2:0];
        return p;
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic [31:0] v);
        cur                = mk(v);
        inValid            = iv;
        outReady           = ordy;
        dataReg1           = cur.d1;
        dataReg2           = cur.d2;
        immValueIn         = cur.imm;
        writeBackAddrIn    = cur.wb;
        ALUop              = cur.op;
        writeEnableReg     = cur.we;
        dataCacheControlIn = cur.dc;
    endtask

    // One clock: check the head of the scoreboard against the outputs, then update it.
    task automatic tick();
        logic in_fire, out_fire;
        @(negedge clk);
        in_fire  = inValid & inReady;
        out_fire = outValid & outReady;
        if (!outValid) begin
            chk("bubble_we", {31'd0, writeEnableAlu}, 32'd0);
            chk("bubble_dc", {29'd0, dataCacheControlOut}, 32'd0);
        end else if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: outValid=1 with no expected entry at %0t", $time);
        end else begin
            chk("out_d1", dataAlu1, sb[0].d1);
            chk("out_d2", dataAlu2, sb[0].d2);
            chk("out_imm", immValueOut, sb[0].imm);
            chk("out_wb", {27'd0, writeBackAddrOut}, {27'd0, sb[0].wb});
            chk("out_op", {28'd0, op}, {28'd0, sb[0].op});
            chk("out_we", {31'd0, writeEnableAlu}, {31'd0, sb[0].we});
            chk("out_dc", {29'd0, dataCacheControlOut}, {29'd0, sb[0].dc});
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (out_fire && sb.size() > 0) void'(sb.pop_front());
            if (in_fire) sb.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'd1,  2'd1, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 32'd2,  2'd1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'd3,  2'd1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'd4,  2'd1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'd0,  2'd0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'hA,  2'd1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 32'hB,  2'd2, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'hC,  2'd2, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'd0,  2'd1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 32'd0,  2'd0, 1'b1};

        rstN  = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 32'h77);
        #13;
        chk("rst_valid", {31'd0, outValid}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_ready", {31'd0, inReady}, 32'd1);
        chk("rst_we", {31'd0, writeEnableAlu}, 32'd0);
        chk("rst_dc", {29'd0, dataCacheControlOut}, 32'd0);
        chk("rst_d1", dataAlu1, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        drive(1'b0, 1'b1, 32'h0);

        // Streaming followed by stall/skid fill and drain
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].d1);
            tick();
            chk($sformatf("vec%0d_occ", i), {30'd0, occupancy}, {30'd0, tbl[i].occ});
            chk($sformatf("vec%0d_rdy", i), {31'd0, inReady}, {31'd0, tbl[i].rdy});
            chk($sformatf("vec%0d_val", i), {31'd0, outValid}, {31'd0, (tbl[i].occ != 2'd0)});
        end

        // Flush while FULL with a same-cycle valid input
        drive(1'b1, 1'b0, 32'h1A);
        tick();
        drive(1'b1, 1'b0, 32'h1B);
        tick();
        chk("pre_flush_occ", {30'd0, occupancy}, 32'd2);
        drive(1'b1, 1'b0, 32'h1F);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, outValid}, 32'd0);
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_we", {31'd0, writeEnableAlu}, 32'd0);
        chk("flush_dc", {29'd0, dataCacheControlOut}, 32'd0);
        drive(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_flush_valid", {31'd0, outValid}, 32'd0);
        end

        // Bubble gating with active control bits on an invalid input
        drive(1'b0, 1'b1, 32'h0);
        writeEnableReg     = 1'b1;
        dataCacheControlIn = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bubble_gate_we", {31'd0, writeEnableAlu}, 32'd0);
            chk("bubble_gate_dc", {29'd0, dataCacheControlOut}, 32'd0);
        end

        // Async reset between edges while FULL
        drive(1'b1, 1'b0, 32'h2A);
        tick();
        drive(1'b1, 1'b0, 32'h2B);
        tick();
        chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        drive(1'b0, 1'b0, 32'h0);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_valid", {31'd0, outValid}, 32'd0);
        chk("arst_we", {31'd0, writeEnableAlu}, 32'd0);
        chk("arst_occ", {30'd0, occupancy}, 32'd0);
        sb.delete();
        tick();
        rstN = 1'b1;
        drive(1'b1, 1'b0, 32'h33);
        tick();
        chk("post_rst_valid", {31'd0, outValid}, 32'd1);
        chk("post_rst_d1", dataAlu1, 32'h33);
        chk("post_rst_occ", {30'd0, occupancy}, 32'd1);
        drive(1'b0, 1'b1, 32'h0);
        tick();
        chk("post_rst_drain", {31'd0, outValid}, 32'd0);

        // Single-entry variant: combinational ready follows outReady
        flush = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        flush = 1'b0;
        drive(1'b1, 1'b0, 32'h55);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("ns_valid", {31'd0, outValid0}, 32'd1);
        chk("ns_d1", dataAlu1_0, 32'h55);
        chk("ns_rdy_stall", {31'd0, inReady0}, 32'd0);
        outReady = 1'b1;
        #1;
        chk("ns_rdy_comb", {31'd0, inReady0}, 32'd1);
        tick();
        tick();
        chk("ns_drain", {31'd0, outValid0}, 32'd0);
        chk("sb_final_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
